exception_status_writeback: RTL and testbench

//  Receiving end of the execute-stage overflow/status path. Takes the per-instruction

---
 rtl/exception_status_writeback.sv | 117 +++++++++++
 tb/tb_exception_status_writeback.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exception_status_writeback.sv
// Overflow/setx status path: carries X-stage events through X/M and M/W, overrides the
// writeback destination with $rstatus, resolves bex with forwarding, counts overflows.
module exception_status_writeback #(
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush_x,
    input  logic             ovf_x,
    input  logic [31:0]      code_x,
    input  logic             setx_x,
    input  logic [26:0]      target_x,
    input  logic             bex_d,
    output logic             wb_override,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [31:0]      rstatus,
    output logic             bex_taken,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    logic              xm_valid_q, xm_valid_d;
    logic              xm_ovf_q,   xm_ovf_d;
    logic [DATA_W-1:0] xm_val_q,   xm_val_d;
    logic              mw_valid_q, mw_valid_d;
    logic              mw_ovf_q,   mw_ovf_d;
    logic [DATA_W-1:0] mw_val_q,   mw_val_d;
    logic [DATA_W-1:0] rstatus_q,  rstatus_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              evt_x_c;
    logic              is_ovf_x_c;
    logic [DATA_W-1:0] val_x_c;
    logic              retire_c;
    logic [DATA_W-1:0] fwd_c;

    // X-stage capture: overflow takes priority over setx; a flush kills both
    always_comb begin
        evt_x_c    = !flush_x && (ovf_x || setx_x);
        is_ovf_x_c = !flush_x && ovf_x;
        val_x_c    = ovf_x ? code_x : {5'b0, target_x};
    end

    assign retire_c = mw_valid_q && !stall;

    // Pipeline advance, $rstatus update and saturating event count
    always_comb begin
        xm_valid_d = xm_valid_q;
        xm_ovf_d   = xm_ovf_q;
        xm_val_d   = xm_val_q;
        mw_valid_d = mw_valid_q;
        mw_ovf_d   = mw_ovf_q;
        mw_val_d   = mw_val_q;
        rstatus_d  = rstatus_q;
        cnt_d      = cnt_q;
        if (!stall) begin
            xm_valid_d = evt_x_c;
            xm_ovf_d   = is_ovf_x_c;
            xm_val_d   = val_x_c;
            mw_valid_d = xm_valid_q;
            mw_ovf_d   = xm_ovf_q;
            mw_val_d   = xm_val_q;
        end
        if (retire_c) begin
            rstatus_d = mw_val_q;
        end
        if (retire_c && mw_ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xm_valid_q <= 1'b0;
            xm_ovf_q   <= 1'b0;
            xm_val_q   <= '0;
            mw_valid_q <= 1'b0;
            mw_ovf_q   <= 1'b0;
            mw_val_q   <= '0;
            rstatus_q  <= '0;
            cnt_q      <= '0;
        end else begin
            xm_valid_q <= xm_valid_d;
            xm_ovf_q   <= xm_ovf_d;
            xm_val_q   <= xm_val_d;
            mw_valid_q <= mw_valid_d;
            mw_ovf_q   <= mw_ovf_d;
            mw_val_q   <= mw_val_d;
            rstatus_q  <= rstatus_d;
            cnt_q      <= cnt_d;
        end
    end

    // bex forwarding, youngest in-flight value first
    always_comb begin
        if (xm_valid_q) begin
            fwd_c = xm_val_q;
        end else if (mw_valid_q) begin
            fwd_c = mw_val_q;
        end else begin
            fwd_c = rstatus_q;
        end
    end

    assign wb_override = mw_valid_q;
    assign wb_rd       = mw_valid_q ? RD_W'(RSTATUS_REG) : '0;
    assign wb_data     = mw_valid_q ? mw_val_q : '0;
    assign rstatus     = rstatus_q;
    assign bex_taken   = bex_d && (fwd_c != '0);
    assign ovf_count   = cnt_q;

endmodule

// File: tb/tb_exception_status_writeback.sv
// Scoreboard bench for exception_status_writeback: stimulus queues expected $rstatus
// writes, a negedge monitor pops them on every retire; register state checked inline.
module tb_exception_status_writeback;

    localparam int unsigned CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             stall;
    logic             flush_x;
    logic             ovf_x;
    logic [31:0]      code_x;
    logic             setx_x;
    logic [26:0]      target_x;
    logic             bex_d;
    logic             wb_override;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [31:0]      rstatus;
    logic             bex_taken;
    logic [CNT_W-1:0] ovf_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    exception_status_writeback #(.RSTATUS_REG(30), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush_x(flush_x),
        .ovf_x(ovf_x), .code_x(code_x), .setx_x(setx_x), .target_x(target_x),
        .bex_d(bex_d), .wb_override(wb_override), .wb_rd(wb_rd), .wb_data(wb_data),
        .rstatus(rstatus), .bex_taken(bex_taken), .ovf_count(ovf_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        flush_x  = 1'b0;
        ovf_x    = 1'b0;
        code_x   = '0;
        setx_x   = 1'b0;
        target_x = '0;
    endtask

    // Monitor: every retiring writeback must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n && wb_override && !stall) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_wb: rd=%0d data=0x%0h at %0t", wb_rd, wb_data, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wb_rd !== 5'd30 || wb_data !== e) begin
                    n_err++;
                    $display("FAIL wb: rd=%0d data=0x%0h expected rd=30 data=0x%0h at %0t",
                             wb_rd, wb_data, e, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        bex_d   = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_rstatus", rstatus, 0);
        chk("rst_count", 32'(ovf_count), 0);
        chk("rst_override", 32'(wb_override), 0);
        chk("rst_bex", 32'(bex_taken), 0);
        bex_d   = 1'b0;
        reset_n = 1'b1;
        tick();

        // Add overflow: visible at writeback two edges later, committed on the third
        ovf_x = 1'b1; code_x = 32'd1; exp_q.push_back(32'd1);
        tick();
        idle();
        tick();
        chk("add_override", 32'(wb_override), 1);
        chk("add_rd", 32'(wb_rd), 30);
        tick();
        chk("add_rstatus", rstatus, 1);
        chk("add_count", 32'(ovf_count), 1);

        // Flushed overflow produces nothing
        flush_x = 1'b1; ovf_x = 1'b1; code_x = 32'd2;
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("flush_rstatus", rstatus, 1);
        chk("flush_count", 32'(ovf_count), 1);

        // Overflow and setx together: overflow code wins
        ovf_x = 1'b1; code_x = 32'd4; setx_x = 1'b1; target_x = 27'd9; exp_q.push_back(32'd4);
        tick();
        idle();
        tick();
        tick();
        chk("prio_rstatus", rstatus, 4);
        chk("prio_count", 32'(ovf_count), 2);

        // bex forwarding from X/M, then a setx 0 masks the older non-zero values
        setx_x = 1'b1; target_x = 27'd7; exp_q.push_back(32'd7);
        tick();
        setx_x = 1'b1; target_x = 27'd0; bex_d = 1'b1; exp_q.push_back(32'd0);
        #1;
        chk("bex_fwd_xm", 32'(bex_taken), 1);
        tick();
        idle();
        #1;
        chk("bex_zero_xm", 32'(bex_taken), 0);
        tick();
        chk("bex_rstatus7", rstatus, 7);
        chk("bex_zero_mw", 32'(bex_taken), 0);
        tick();
        chk("bex_zero_rf", 32'(bex_taken), 0);
        chk("setx_rstatus0", rstatus, 0);
        chk("setx_nocount", 32'(ovf_count), 2);
        bex_d = 1'b0;

        // Stall with the event in X/M: nothing moves and X is not sampled
        ovf_x = 1'b1; code_x = 32'd3; exp_q.push_back(32'd3);
        tick();
        stall = 1'b1; ovf_x = 1'b1; code_x = 32'd5; bex_d = 1'b1;
        tick();
        tick();
        tick();
        chk("stall_xm_override", 32'(wb_override), 0);
        chk("stall_xm_bex", 32'(bex_taken), 1);
        stall = 1'b0; bex_d = 1'b0;
        idle();
        tick();
        chk("stall_mw_override", 32'(wb_override), 1);
        stall = 1'b1;
        tick();
        tick();
        tick();
        chk("stall_mw_held", 32'(wb_override), 1);
        chk("stall_rstatus", rstatus, 0);
        chk("stall_count", 32'(ovf_count), 2);
        stall = 1'b0;
        tick();
        chk("release_rstatus", rstatus, 3);
        chk("release_count", 32'(ovf_count), 3);
        tick();
        chk("release_once", 32'(wb_override), 0);
        chk("release_count2", 32'(ovf_count), 3);

        // Back-to-back overflows beyond saturation
        ovf_x = 1'b1; code_x = 32'd3; exp_q.push_back(32'd3);
        tick();
        ovf_x = 1'b1; code_x = 32'd5; exp_q.push_back(32'd5);
        tick();
        idle();
        tick();
        chk("b2b_mid_rstatus", rstatus, 3);
        tick();
        chk("b2b_rstatus", rstatus, 5);
        chk("sat_count", 32'(ovf_count), 3);

        // Reset with an event in X/M: discarded, all outputs cleared
        ovf_x = 1'b1; code_x = 32'd2;
        tick();
        idle();
        bex_d = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_override", 32'(wb_override), 0);
        chk("mid_rst_rd", 32'(wb_rd), 0);
        chk("mid_rst_data", wb_data, 0);
        chk("mid_rst_rstatus", rstatus, 0);
        chk("mid_rst_count", 32'(ovf_count), 0);
        chk("mid_rst_bex", 32'(bex_taken), 0);
        tick();
        reset_n = 1'b1;
        bex_d = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_rstatus", rstatus, 0);
        chk("post_rst_override", 32'(wb_override), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
